operand_fetch_ctrl: RTL and testbench

OPERAND_FETCH_CTRL -- requirements
Module: operand_fetch_ctrl

---
 rtl/operand_fetch_ctrl_pkg.sv | 14 +
 rtl/operand_scoreboard.sv | 58 +++++
 rtl/operand_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_operand_fetch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared sizing constants and FSM encoding for the operand fetch controller.
package operand_fetch_ctrl_pkg;

    localparam int unsigned REG_W = 16;
    localparam int unsigned REG_N = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/operand_scoreboard.sv
// Register scoreboard: tracks pending writes and flags read/write hazards
// for the currently latched instruction.
module operand_scoreboard
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int unsigned REG_N = operand_fetch_ctrl_pkg::REG_N,
    parameter int unsigned IDX_W = operand_fetch_ctrl_pkg::IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_dst,
    input  logic [IDX_W-1:0] src1,
    input  logic [IDX_W-1:0] src2,
    input  logic [IDX_W-1:0] dst,
    input  logic             dst_chk,
    output logic             hazard,
    output logic [REG_N-1:0] busy
);

    logic [REG_N-1:0] busy_q, busy_d;
    logic [REG_N-1:0] haz_vec;

    // A writeback landing this cycle resolves the hazard on its register.
    always_comb begin
        haz_vec = '0;
        for (int i = 1; i < REG_N; i++) begin
            haz_vec[i] = busy_q[i] && !(wb_valid && (wb_dst == IDX_W'(i)));
        end
    end

    assign hazard = haz_vec[src1] | haz_vec[src2] | (dst_chk & haz_vec[dst]);

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_dst] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: latches a decoded request, stalls on scoreboard
// hazards, forwards same-cycle writebacks and holds the operand bundle.
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = operand_fetch_ctrl_pkg::REG_W,
    parameter int unsigned REG_N = operand_fetch_ctrl_pkg::REG_N,
    parameter int unsigned IDX_W = operand_fetch_ctrl_pkg::IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_src1,
    input  logic [IDX_W-1:0] req_src2,
    input  logic [IDX_W-1:0] req_dst,
    input  logic             req_wr,
    output logic [IDX_W-1:0] rf_src1,
    output logic [IDX_W-1:0] rf_src2,
    input  logic [REG_W-1:0] rf_data1,
    input  logic [REG_W-1:0] rf_data2,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [REG_W-1:0] op_a,
    output logic [REG_W-1:0] op_b,
    output logic [IDX_W-1:0] op_dst,
    output logic             op_wr,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [IDX_W-1:0] wb_dst,
    input  logic [REG_W-1:0] wb_data,
    output logic [IDX_W-1:0] rf_dst,
    output logic [REG_W-1:0] rf_wdata,
    output logic             rf_we,
    output logic [REG_N-1:0] busy
);

    fetch_state_e     state_q, state_d;
    logic [IDX_W-1:0] src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic             wr_q, wr_d;
    logic [REG_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [IDX_W-1:0] op_dst_q, op_dst_d;
    logic             op_wr_q, op_wr_d;
    logic             hazard, issue;
    logic [REG_W-1:0] fwd1, fwd2;

    operand_scoreboard #(
        .REG_N (REG_N),
        .IDX_W (IDX_W)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (issue && wr_q),
        .set_idx  (dst_q),
        .wb_valid (wb_valid),
        .wb_dst   (wb_dst),
        .src1     (src1_q),
        .src2     (src2_q),
        .dst      (dst_q),
        .dst_chk  (wr_q),
        .hazard   (hazard),
        .busy     (busy)
    );

    // R0 is hard zero and never takes a forwarded value.
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        if (src1_q != '0) begin
            fwd1 = (wb_valid && (wb_dst == src1_q)) ? wb_data : rf_data1;
        end
        if (src2_q != '0) begin
            fwd2 = (wb_valid && (wb_dst == src2_q)) ? wb_data : rf_data2;
        end
    end

    assign issue = (state_q == StRead) && !hazard;

    always_comb begin
        state_d  = state_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dst_d    = dst_q;
        wr_d     = wr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_dst_d = op_dst_q;
        op_wr_d  = op_wr_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    src1_d  = req_src1;
                    src2_d  = req_src2;
                    dst_d   = req_dst;
                    wr_d    = req_wr;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (!hazard) begin
                    op_a_d   = fwd1;
                    op_b_d   = fwd2;
                    op_dst_d = dst_q;
                    op_wr_d  = wr_q;
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (op_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            wr_q     <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_dst_q <= '0;
            op_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dst_q    <= dst_d;
            wr_q     <= wr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_dst_q <= op_dst_d;
            op_wr_q  <= op_wr_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign op_valid  = (state_q == StHold);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_dst    = op_dst_q;
    assign op_wr     = op_wr_q;
    assign rf_src1   = src1_q;
    assign rf_src2   = src2_q;

    assign wb_ready  = 1'b1;
    assign rf_we     = wb_valid;
    assign rf_dst    = wb_dst;
    assign rf_wdata  = wb_data;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: directed scenarios plus randomized requests
// and writebacks checked against a transaction-level scoreboard model.
module tb_operand_fetch_ctrl;

    localparam int REG_W = 16;
    localparam int REG_N = 8;
    localparam int IDX_W = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [IDX_W-1:0] req_src1 = '0, req_src2 = '0, req_dst = '0;
    logic [IDX_W-1:0] rf_src1, rf_src2, op_dst, wb_dst = '0, rf_dst;
    logic [REG_W-1:0] rf_data1, rf_data2, op_a, op_b, wb_data = '0, rf_wdata;
    logic             op_valid, op_ready = 1'b0, op_wr, wb_valid = 1'b0, wb_ready, rf_we;
    logic [REG_N-1:0] busy;

    logic [REG_W-1:0] rf   [REG_N];
    logic [REG_W-1:0] arch [REG_N];
    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    // Register file environment: R0 reads zero, writes ignored during reset.
    assign rf_data1 = (rf_src1 == '0) ? '0 : rf[rf_src1];
    assign rf_data2 = (rf_src2 == '0) ? '0 : rf[rf_src2];
    always @(posedge clock) begin
        if (rf_we && !reset && rf_dst != '0) rf[rf_dst] <= rf_wdata;
    end

    operand_fetch_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_wr(req_wr),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_dst(op_dst), .op_wr(op_wr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst), .wb_data(wb_data),
        .rf_dst(rf_dst), .rf_wdata(rf_wdata), .rf_we(rf_we), .busy(busy)
    );

    function automatic bit blocked(input logic [IDX_W-1:0] k, input logic [REG_N-1:0] pend,
                                   input bit wv, input logic [IDX_W-1:0] wd);
        return (k != 0) && pend[k] && !(wv && wd == k);
    endfunction

    task automatic send_req(input int s1, input int s2, input int d, input bit w);
        req_valid = 1'b1;
        req_src1 = IDX_W'(s1);
        req_src2 = IDX_W'(s2);
        req_dst = IDX_W'(d);
        req_wr = w;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [REG_W-1:0] v;
        repeat (2) @(negedge clock);
        tests++; if ({req_ready, op_valid} !== 2'b10) begin
            fails++; $display("FAIL reset_handshake: got %b expected 10", {req_ready, op_valid});
        end
        tests++; if (busy !== 8'h00) begin
            fails++; $display("FAIL reset_busy: got %h expected 00", busy);
        end
        tests++; if ({op_a, op_b, op_dst, op_wr} !== '0) begin
            fails++; $display("FAIL reset_op: got %h %h %h %b expected zeros", op_a, op_b, op_dst, op_wr);
        end
        tests++; if ({rf_src1, rf_src2} !== '0) begin
            fails++; $display("FAIL reset_idx: got %h %h expected 0 0", rf_src1, rf_src2);
        end
        wb_valid = 1'b1; wb_dst = 3'd5; wb_data = 16'h5555;
        #1;
        tests++; if (rf_we !== 1'b1) begin
            fails++; $display("FAIL reset_rf_we: got %b expected 1", rf_we);
        end
        @(negedge clock);
        reset = 1'b0;
        arch[0] = '0;
        for (int i = 1; i < REG_N; i++) begin
            v = (i == 1) ? 16'd5 : (i == 2) ? 16'd7 : REG_W'($urandom);
            wb_valid = 1'b1; wb_dst = IDX_W'(i); wb_data = v;
            arch[i] = v;
            #1;
            tests++; if ({rf_we, rf_dst, rf_wdata, wb_ready} !== {1'b1, IDX_W'(i), v, 1'b1}) begin
                fails++; $display("FAIL wb_passthru: got %b %h %h expected 1 %0d %h",
                                  rf_we, rf_dst, rf_wdata, i, v);
            end
            @(negedge clock);
        end
        wb_valid = 1'b0;
        tests++; if (busy !== 8'h00) begin
            fails++; $display("FAIL load_busy: got %h expected 00", busy);
        end
    endtask

    task automatic test_basic;
        op_ready = 1'b0;
        send_req(1, 2, 3, 1'b1);
        tests++; if ({op_valid, req_ready, rf_src1, rf_src2} !== {2'b00, 3'd1, 3'd2}) begin
            fails++; $display("FAIL basic_read: got %b %b %h %h expected 0 0 1 2",
                              op_valid, req_ready, rf_src1, rf_src2);
        end
        @(negedge clock);
        tests++; if ({op_valid, op_a, op_b, op_dst, op_wr} !== {1'b1, 16'd5, 16'd7, 3'd3, 1'b1}) begin
            fails++; $display("FAIL basic_bundle: got %b %h %h %h %b expected 1 0005 0007 3 1",
                              op_valid, op_a, op_b, op_dst, op_wr);
        end
        tests++; if (busy !== 8'h08) begin
            fails++; $display("FAIL basic_busy: got %h expected 08", busy);
        end
        op_ready = 1'b1;
        @(negedge clock);
        tests++; if ({op_valid, req_ready} !== 2'b01) begin
            fails++; $display("FAIL basic_release: got %b expected 01", {op_valid, req_ready});
        end
    endtask

    task automatic test_forward;
        send_req(3, 1, 5, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            tests++; if ({op_valid, busy} !== {1'b0, 8'h08}) begin
                fails++; $display("FAIL fwd_stall: got %b %h expected 0 08", op_valid, busy);
            end
        end
        wb_valid = 1'b1; wb_dst = 3'd3; wb_data = 16'h1234;
        arch[3] = 16'h1234;
        @(negedge clock);
        wb_valid = 1'b0;
        tests++; if ({op_valid, op_a, op_b} !== {1'b1, 16'h1234, arch[1]}) begin
            fails++; $display("FAIL fwd_bundle: got %b %h %h expected 1 1234 %h",
                              op_valid, op_a, op_b, arch[1]);
        end
        tests++; if (busy !== 8'h00) begin
            fails++; $display("FAIL fwd_busy_clear: got %h expected 00", busy);
        end
        @(negedge clock);
    endtask

    task automatic test_zero;
        send_req(0, 0, 0, 1'b1);
        wb_valid = 1'b1; wb_dst = 3'd0; wb_data = 16'hffff;
        @(negedge clock);
        wb_valid = 1'b0;
        tests++; if ({op_valid, op_a, op_b, op_dst} !== {1'b1, 32'h0, 3'd0}) begin
            fails++; $display("FAIL zero_bundle: got %b %h %h %h expected 1 0000 0000 0",
                              op_valid, op_a, op_b, op_dst);
        end
        tests++; if (busy !== 8'h00) begin
            fails++; $display("FAIL zero_busy: got %h expected 00", busy);
        end
        @(negedge clock);
    endtask

    task automatic test_hold;
        op_ready = 1'b0;
        send_req(1, 2, 0, 1'b0);
        @(negedge clock);
        for (int c = 0; c < 4; c++) begin
            tests++; if ({op_valid, req_ready, op_a, op_b} !== {2'b10, arch[1], arch[2]}) begin
                fails++; $display("FAIL hold_stable: got %b %b %h %h expected 1 0 %h %h",
                                  op_valid, req_ready, op_a, op_b, arch[1], arch[2]);
            end
            @(negedge clock);
        end
        tests++; if (op_valid !== 1'b1) begin
            fails++; $display("FAIL hold_still_valid: got %b expected 1", op_valid);
        end
        op_ready = 1'b1;
        @(negedge clock);
        tests++; if ({op_valid, req_ready} !== 2'b01) begin
            fails++; $display("FAIL hold_release: got %b expected 01", {op_valid, req_ready});
        end
    endtask

    task automatic test_wb_same;
        send_req(1, 2, 4, 1'b1);
        wb_valid = 1'b1; wb_dst = 3'd4; wb_data = 16'habcd;
        arch[4] = 16'habcd;
        #1;
        tests++; if ({rf_we, rf_dst} !== {1'b1, 3'd4}) begin
            fails++; $display("FAIL same_rf_we: got %b %h expected 1 4", rf_we, rf_dst);
        end
        @(negedge clock);
        wb_valid = 1'b0;
        tests++; if ({op_valid, op_dst, busy} !== {1'b1, 3'd4, 8'h10}) begin
            fails++; $display("FAIL same_set_wins: got %b %h %h expected 1 4 10", op_valid, op_dst, busy);
        end
        @(negedge clock);
        wb_valid = 1'b1; wb_dst = 3'd2; wb_data = 16'h2222;
        arch[2] = 16'h2222;
        @(negedge clock);
        tests++; if (busy !== 8'h10) begin
            fails++; $display("FAIL nonbusy_wb: got %h expected 10", busy);
        end
        wb_dst = 3'd4; wb_data = 16'h4444;
        arch[4] = 16'h4444;
        @(negedge clock);
        wb_valid = 1'b0;
        tests++; if (busy !== 8'h00) begin
            fails++; $display("FAIL wb_clear: got %h expected 00", busy);
        end
    endtask

    task automatic test_reset_mid;
        op_ready = 1'b1;
        send_req(0, 0, 6, 1'b1);
        repeat (2) @(negedge clock);
        send_req(6, 0, 1, 1'b0);
        @(negedge clock);
        tests++; if ({op_valid, busy} !== {1'b0, 8'h40}) begin
            fails++; $display("FAIL mid_stall: got %b %h expected 0 40", op_valid, busy);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests++; if ({req_ready, op_valid, busy, rf_src1} !== {2'b10, 8'h00, 3'd0}) begin
            fails++; $display("FAIL mid_reset: got %b %b %h %h expected 1 0 00 0",
                              req_ready, op_valid, busy, rf_src1);
        end
        @(negedge clock);
        tests++; if ({op_valid, busy} !== {1'b0, 8'h00}) begin
            fails++; $display("FAIL mid_reset_after: got %b %h expected 0 00", op_valid, busy);
        end
    endtask

    task automatic test_random(input int n);
        logic [IDX_W-1:0] s1, s2, d, wd;
        logic [REG_W-1:0] ea, eb, wdat;
        logic [REG_N-1:0] pend;
        bit w, wv, issued;
        int q[$];
        int hold;
        pend = '0;
        for (int t = 0; t < n; t++) begin
            s1 = IDX_W'($urandom); s2 = IDX_W'($urandom);
            d = IDX_W'($urandom); w = 1'($urandom);
            op_ready = 1'b0;
            tests++; if (req_ready !== 1'b1) begin
                fails++; $display("FAIL rnd_ready: got %b expected 1", req_ready);
            end
            send_req(int'(s1), int'(s2), int'(d), w);
            issued = 1'b0;
            ea = '0; eb = '0;
            for (int c = 0; c < 200 && !issued; c++) begin
                wv = 1'b0; wd = '0; wdat = REG_W'($urandom);
                if (pend != 0 && $urandom_range(3, 0) != 0) begin
                    wv = 1'b1;
                    if (pend[s1] && $urandom_range(1, 0) == 1) wd = s1;
                    else begin
                        q.delete();
                        for (int k = 1; k < REG_N; k++) if (pend[k]) q.push_back(k);
                        wd = IDX_W'(q[$urandom_range(q.size() - 1, 0)]);
                    end
                end
                wb_valid = wv; wb_dst = wd; wb_data = wdat;
                issued = !(blocked(s1, pend, wv, wd) || blocked(s2, pend, wv, wd) ||
                           (w && blocked(d, pend, wv, wd)));
                ea = (s1 == 0) ? '0 : (wv && wd == s1) ? wdat : arch[s1];
                eb = (s2 == 0) ? '0 : (wv && wd == s2) ? wdat : arch[s2];
                @(negedge clock);
                wb_valid = 1'b0;
                if (wv) begin
                    pend[wd] = 1'b0;
                    arch[wd] = wdat;
                end
                if (issued && w && d != 0) pend[d] = 1'b1;
                tests++; if (op_valid !== issued) begin
                    fails++; $display("FAIL rnd_issue: got %b expected %b (src %0d %0d dst %0d)",
                                      op_valid, issued, s1, s2, d);
                end
                tests++; if (busy !== pend) begin
                    fails++; $display("FAIL rnd_busy: got %h expected %h", busy, pend);
                end
            end
            if (!issued) begin
                tests++; fails++;
                $display("FAIL rnd_timeout: got no issue expected issue within 200 cycles");
                return;
            end
            tests++; if ({op_a, op_b, op_dst, op_wr} !== {ea, eb, d, w}) begin
                fails++; $display("FAIL rnd_bundle: got %h %h %h %b expected %h %h %h %b",
                                  op_a, op_b, op_dst, op_wr, ea, eb, d, w);
            end
            hold = $urandom_range(2, 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clock);
                tests++; if ({op_valid, op_a, op_b} !== {1'b1, ea, eb}) begin
                    fails++; $display("FAIL rnd_hold: got %b %h %h expected 1 %h %h",
                                      op_valid, op_a, op_b, ea, eb);
                end
            end
            op_ready = 1'b1;
            @(negedge clock);
            op_ready = 1'b0;
            tests++; if ({op_valid, req_ready} !== 2'b01) begin
                fails++; $display("FAIL rnd_release: got %b expected 01", {op_valid, req_ready});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_zero();
        test_hold();
        test_wb_same();
        test_reset_mid();
        test_random(60);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
